// File: rtl/hplvds_link_ctrl.sv
// Power-up / link sequencer for one HPLVDS pad pair: settle-timed enables, TX electrical-idle
// minimum and a synchronized RX idle indication. Define HPLVDS_EI_FILTER_EN to add the EI detect filter.
module hplvds_link_ctrl #(
    parameter int unsigned SETTLE_CYC  = 64,
    parameter int unsigned EI_MIN_CYC  = 16,
    parameter int unsigned EI_FILT_CYC = 8
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic link_en_i,
    input  logic rx_mode_i,
    input  logic tx_ei_req_i,
    output logic ready_o,
    output logic rx_idle_o,
    output logic pad_rterm_en_o,
    output logic pad_rx_en_o,
    output logic pad_rx_vcm_en_o,
    output logic pad_ei_detect_en_o,
    output logic pad_tx_en_o,
    output logic pad_tx_vcm_en_o,
    output logic pad_tx_ei_o,
    input  logic pad_ei_detect_i
);

    localparam int unsigned CNT_MAX = (SETTLE_CYC > EI_MIN_CYC) ? SETTLE_CYC : EI_MIN_CYC;
    localparam int unsigned CW      = $clog2(CNT_MAX);
    localparam logic [CW-1:0] SETTLE_LD = CW'(SETTLE_CYC - 1);
    localparam logic [CW-1:0] EI_LD     = CW'(EI_MIN_CYC - 1);

    typedef enum logic [2:0] {ST_OFF, ST_TERM, ST_ENABLE, ST_ACTIVE, ST_DRAIN} state_e;

    state_e        state_q;
    logic [CW-1:0] cnt_q;
    logic          mode_q;
    logic          ready_q, rx_idle_q;
    logic          rterm_q, rx_en_q, rx_vcm_q, det_q;
    logic          tx_en_q, tx_vcm_q, tx_ei_q;
    logic [1:0]    sync_q;
    logic          filt_d;

    always_ff @(posedge clk_i) begin
        if (rst_i) sync_q <= 2'b11;
        else       sync_q <= {sync_q[0], pad_ei_detect_i};
    end

`ifdef HPLVDS_EI_FILTER_EN
    localparam int unsigned FW = (EI_FILT_CYC > 1) ? $clog2(EI_FILT_CYC) : 1;
    localparam logic [FW-1:0] FILT_LAST = FW'(EI_FILT_CYC - 1);

    logic          filt_q;
    logic [FW-1:0] fcnt_q, fcnt_d;

    // Counts consecutive samples disagreeing with the filtered level; any agreement restarts it.
    always_comb begin
        filt_d = filt_q;
        fcnt_d = '0;
        if (sync_q[1] != filt_q) begin
            if (fcnt_q == FILT_LAST) filt_d = sync_q[1];
            else                     fcnt_d = fcnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            filt_q <= 1'b1;
            fcnt_q <= '0;
        end else begin
            filt_q <= filt_d;
            fcnt_q <= fcnt_d;
        end
    end
`else
    logic unused_filt_cfg;
    assign unused_filt_cfg = (EI_FILT_CYC != 0);
    assign filt_d = sync_q[1];
`endif

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= ST_OFF;
            cnt_q     <= '0;
            mode_q    <= 1'b0;
            ready_q   <= 1'b0;
            rx_idle_q <= 1'b1;
            rterm_q   <= 1'b0;
            rx_en_q   <= 1'b0;
            rx_vcm_q  <= 1'b0;
            det_q     <= 1'b0;
            tx_en_q   <= 1'b0;
            tx_vcm_q  <= 1'b0;
            tx_ei_q   <= 1'b0;
        end else begin
            ready_q   <= (state_q == ST_ACTIVE);
            rx_idle_q <= (state_q == ST_ACTIVE && mode_q) ? filt_d : 1'b1;
            case (state_q)
                ST_OFF: begin
                    rterm_q  <= 1'b0;
                    rx_en_q  <= 1'b0;
                    rx_vcm_q <= 1'b0;
                    det_q    <= 1'b0;
                    tx_en_q  <= 1'b0;
                    tx_vcm_q <= 1'b0;
                    tx_ei_q  <= 1'b0;
                    if (link_en_i) begin
                        mode_q  <= rx_mode_i;
                        cnt_q   <= SETTLE_LD;
                        state_q <= ST_TERM;
                    end
                end
                ST_TERM: begin
                    rterm_q  <= mode_q;
                    rx_vcm_q <= mode_q;
                    tx_vcm_q <= !mode_q;
                    rx_en_q  <= 1'b0;
                    det_q    <= 1'b0;
                    tx_en_q  <= 1'b0;
                    tx_ei_q  <= 1'b0;
                    if (!link_en_i) begin
                        cnt_q   <= EI_LD;
                        state_q <= ST_DRAIN;
                    end else if (cnt_q == '0) begin
                        cnt_q   <= SETTLE_LD;
                        state_q <= ST_ENABLE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ENABLE: begin
                    rterm_q  <= mode_q;
                    rx_vcm_q <= mode_q;
                    rx_en_q  <= mode_q;
                    det_q    <= mode_q;
                    tx_vcm_q <= !mode_q;
                    tx_en_q  <= !mode_q;
                    tx_ei_q  <= !mode_q;
                    if (!link_en_i) begin
                        cnt_q   <= EI_LD;
                        state_q <= ST_DRAIN;
                    end else if (cnt_q == '0) begin
                        // Forced idle from ENABLE counts as an assertion starting at ACTIVE entry
                        cnt_q   <= EI_LD;
                        state_q <= ST_ACTIVE;
                    end else begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_ACTIVE: begin
                    rterm_q  <= mode_q;
                    rx_vcm_q <= mode_q;
                    rx_en_q  <= mode_q;
                    det_q    <= mode_q;
                    tx_vcm_q <= !mode_q;
                    tx_en_q  <= !mode_q;
                    tx_ei_q  <= !mode_q && (tx_ei_req_i || (tx_ei_q && cnt_q != '0));
                    if (!link_en_i) begin
                        cnt_q   <= EI_LD;
                        state_q <= ST_DRAIN;
                    end else if (!mode_q && tx_ei_req_i && !tx_ei_q) begin
                        cnt_q <= EI_LD;
                    end else if (cnt_q != '0) begin
                        cnt_q <= cnt_q - 1'b1;
                    end
                end
                ST_DRAIN: begin
                    tx_ei_q <= !mode_q;
                    rx_en_q <= 1'b0;
                    det_q   <= 1'b0;
                    if (cnt_q == '0) state_q <= ST_OFF;
                    else             cnt_q   <= cnt_q - 1'b1;
                end
                default: state_q <= ST_OFF;
            endcase
        end
    end

    assign ready_o            = ready_q;
    assign rx_idle_o          = rx_idle_q;
    assign pad_rterm_en_o     = rterm_q;
    assign pad_rx_en_o        = rx_en_q;
    assign pad_rx_vcm_en_o    = rx_vcm_q;
    assign pad_ei_detect_en_o = det_q;
    assign pad_tx_en_o        = tx_en_q;
    assign pad_tx_vcm_en_o    = tx_vcm_q;
    assign pad_tx_ei_o        = tx_ei_q;

endmodule

// File: tb/tb_hplvds_link_ctrl.sv
// Bench for hplvds_link_ctrl: directed sequences plus random stimulus against a timestamp-based model.
module tb_hplvds_link_ctrl;

    localparam int unsigned S_P = 4;
    localparam int unsigned E_P = 3;
    localparam int unsigned F_P = 8;
`ifdef HPLVDS_EI_FILTER_EN
    localparam int unsigned LAT = 2 + F_P;
`else
    localparam int unsigned LAT = 3;
`endif
    localparam int P_OFF = 0, P_TERM = 1, P_EN = 2, P_ACT = 3, P_DRAIN = 4;

    logic clk = 1'b0;
    logic rst_i, link_en_i, rx_mode_i, tx_ei_req_i, pad_ei_detect_i;
    logic ready_o, rx_idle_o;
    logic pad_rterm_en_o, pad_rx_en_o, pad_rx_vcm_en_o, pad_ei_detect_en_o;
    logic pad_tx_en_o, pad_tx_vcm_en_o, pad_tx_ei_o;

    always #5 clk = ~clk;

    hplvds_link_ctrl #(
        .SETTLE_CYC (S_P),
        .EI_MIN_CYC (E_P),
        .EI_FILT_CYC(F_P)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst_i),
        .link_en_i         (link_en_i),
        .rx_mode_i         (rx_mode_i),
        .tx_ei_req_i       (tx_ei_req_i),
        .ready_o           (ready_o),
        .rx_idle_o         (rx_idle_o),
        .pad_rterm_en_o    (pad_rterm_en_o),
        .pad_rx_en_o       (pad_rx_en_o),
        .pad_rx_vcm_en_o   (pad_rx_vcm_en_o),
        .pad_ei_detect_en_o(pad_ei_detect_en_o),
        .pad_tx_en_o       (pad_tx_en_o),
        .pad_tx_vcm_en_o   (pad_tx_vcm_en_o),
        .pad_tx_ei_o       (pad_tx_ei_o),
        .pad_ei_detect_i   (pad_ei_detect_i)
    );

    int unsigned n_total = 0;
    int unsigned n_bad   = 0;

    // Reference model: phase + entry timestamps, EI rise timestamp, pad sample history
    int m_ph = P_OFF, m_t = 0, m_enter = 0, m_rise = 0;
    bit m_mode, m_filt;
    bit hist[$];
    bit e_ready, e_idle, e_rterm, e_rxen, e_rxvcm, e_det, e_txen, e_txvcm, e_txei;
    bit len_r = 1'b0, pad_r = 1'b1;

    task automatic check_eq(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_edge(input bit rst, input bit len, input bit md, input bit req, input bit pad);
        bit en_set, prev_ei, all_same;
        m_t++;
        if (rst) begin
            m_ph = P_OFF; m_mode = 1'b0; m_filt = 1'b1;
            hist.delete();
            for (int i = 0; i < int'(F_P) + 3; i++) hist.push_back(1'b1);
            {e_ready, e_rterm, e_rxen, e_rxvcm, e_det, e_txen, e_txvcm, e_txei} = '0;
            e_idle = 1'b1;
            return;
        end
        hist.push_back(pad);
        void'(hist.pop_front());
`ifdef HPLVDS_EI_FILTER_EN
        all_same = 1'b1;
        for (int i = 0; i < int'(F_P); i++)
            if (hist[hist.size() - 3 - i] == m_filt) all_same = 1'b0;
        if (all_same) m_filt = !m_filt;
`else
        all_same = 1'b0;
        m_filt = hist[hist.size() - 3];
`endif
        e_idle  = (m_ph == P_ACT && m_mode) ? m_filt : 1'b1;
        e_ready = (m_ph == P_ACT);
        prev_ei = e_txei;
        case (m_ph)
            P_OFF: {e_rterm, e_rxen, e_rxvcm, e_det, e_txen, e_txvcm, e_txei} = '0;
            P_TERM, P_EN, P_ACT: begin
                en_set  = (m_ph != P_TERM);
                e_txvcm = !m_mode;
                e_rterm = m_mode;
                e_rxvcm = m_mode;
                e_txen  = en_set && !m_mode;
                e_rxen  = en_set && m_mode;
                e_det   = en_set && m_mode;
                e_txei  = en_set && !m_mode;
                if (m_ph == P_ACT && !m_mode) begin
                    if (req) begin
                        e_txei = 1'b1;
                        if (!prev_ei) m_rise = m_t;
                    end else begin
                        e_txei = prev_ei && (m_t - m_rise < int'(E_P));
                    end
                end
            end
            default: begin
                e_txei = !m_mode;
                e_rxen = 1'b0;
                e_det  = 1'b0;
            end
        endcase
        case (m_ph)
            P_OFF: if (len) begin m_ph = P_TERM; m_enter = m_t; m_mode = md; end
            P_DRAIN: if (m_t - m_enter == int'(E_P)) m_ph = P_OFF;
            default: begin
                if (!len) begin
                    m_ph = P_DRAIN; m_enter = m_t;
                end else if (m_ph != P_ACT && m_t - m_enter == int'(S_P)) begin
                    m_ph = m_ph + 1; m_enter = m_t;
                    if (m_ph == P_ACT) m_rise = m_t;
                end
            end
        endcase
    endtask

    task automatic cycle(input bit rst, input bit len, input bit md, input bit req, input bit pad);
        rst_i = rst; link_en_i = len; rx_mode_i = md; tx_ei_req_i = req; pad_ei_detect_i = pad;
        model_edge(rst, len, md, req, pad);
        @(posedge clk);
        #1;
        check_eq("ready",    8'(ready_o),            8'(e_ready));
        check_eq("rx_idle",  8'(rx_idle_o),          8'(e_idle));
        check_eq("rterm",    8'(pad_rterm_en_o),     8'(e_rterm));
        check_eq("rx_en",    8'(pad_rx_en_o),        8'(e_rxen));
        check_eq("rx_vcm",   8'(pad_rx_vcm_en_o),    8'(e_rxvcm));
        check_eq("ei_det",   8'(pad_ei_detect_en_o), 8'(e_det));
        check_eq("tx_en",    8'(pad_tx_en_o),        8'(e_txen));
        check_eq("tx_vcm",   8'(pad_tx_vcm_en_o),    8'(e_txvcm));
        check_eq("tx_ei",    8'(pad_tx_ei_o),        8'(e_txei));
    endtask

    initial begin
        cycle(1, 0, 0, 0, 1);
        cycle(1, 0, 0, 0, 1);
        check_eq("rst_pads", 8'({pad_rterm_en_o, pad_rx_en_o, pad_rx_vcm_en_o, pad_ei_detect_en_o,
                                 pad_tx_en_o, pad_tx_vcm_en_o, pad_tx_ei_o, ready_o}), 8'd0);
        check_eq("rst_idle", 8'(rx_idle_o), 8'd1);

        // TX bring-up; rx_mode_i toggles after the OFF sample and must be ignored
        for (int k = 0; k <= 12; k++) begin
            cycle(0, 1, (k > 0) && (k % 2 == 1), 0, 1);
            check_eq("up_txvcm", 8'(pad_tx_vcm_en_o), 8'(k >= 1));
            check_eq("up_txen",  8'(pad_tx_en_o),     8'(k >= 5));
            check_eq("up_txei",  8'(pad_tx_ei_o),     8'(k >= 5 && k <= 10));
            check_eq("up_ready", 8'(ready_o),         8'(k >= 9));
            check_eq("up_rterm", 8'(pad_rterm_en_o),  8'd0);
        end

        for (int j = 0; j < 10; j++) begin
            cycle(0, 1, 0, (j == 0) || (j == 5), 1);
            check_eq("ei_min", 8'(pad_tx_ei_o), 8'((j % 5) < 3));
        end

        for (int j = 0; j <= int'(E_P) + 2; j++) begin
            cycle(0, 0, 0, 0, 1);
            check_eq("dn_txen",  8'(pad_tx_en_o), 8'(j <= int'(E_P)));
            check_eq("dn_txei",  8'(pad_tx_ei_o), 8'(j >= 1 && j <= int'(E_P)));
            check_eq("dn_ready", 8'(ready_o),     8'(j == 0));
        end

        // RX bring-up with a quiet pad
        for (int j = 0; j < 2 * int'(S_P) + int'(LAT) + 4; j++) cycle(0, 1, j == 0, 0, 0);
        check_eq("rx_ready", 8'(ready_o),   8'd1);
        check_eq("rx_quiet", 8'(rx_idle_o), 8'd0);

        for (int j = 0; j < 17; j++) begin
            cycle(0, 1, 0, 0, (j < 5) && (j % 2 == 0));
`ifdef HPLVDS_EI_FILTER_EN
            check_eq("glitch_idle", 8'(rx_idle_o), 8'd0);
`endif
        end

        for (int j = 1; j <= int'(LAT) + 3; j++) begin
            cycle(0, 1, 0, 0, 1);
            check_eq("idle_lat", 8'(rx_idle_o), 8'(j >= int'(LAT)));
        end

        // RX teardown, link re-raised during DRAIN, restart through ENABLE, then reset
        for (int j = 0; j <= int'(E_P + S_P) + 2; j++) begin
            cycle(0, j != 0, 1, 0, 1);
            check_eq("td_ready", 8'(ready_o),        8'(j == 0));
            check_eq("td_rxen",  8'(pad_rx_en_o),    8'((j == 0) || (j == int'(E_P + S_P) + 2)));
            check_eq("td_rterm", 8'(pad_rterm_en_o), 8'(j != int'(E_P) + 1));
        end
        cycle(1, 1, 1, 0, 0);
        check_eq("rst_en_pads", 8'({pad_rterm_en_o, pad_rx_en_o, pad_rx_vcm_en_o, pad_ei_detect_en_o,
                                    pad_tx_en_o, pad_tx_vcm_en_o, pad_tx_ei_o, ready_o}), 8'd0);
        check_eq("rst_en_idle", 8'(rx_idle_o), 8'd1);
        cycle(0, 0, 0, 0, 1);

        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 29) == 0) len_r = !len_r;
            if ($urandom_range(0, 5) == 0)  pad_r = !pad_r;
            cycle($urandom_range(0, 399) == 0, len_r, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, pad_r);
        end

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/hplvds_link_ctrl.md
# hplvds_link_ctrl

Power-up and link sequencer for one HPLVDS differential pad pair. It drives the pad's enable and control pins in a fixed settle-timed order: termination or common-mode first, then driver or receiver, then active. It manages transmitter electrical-idle entry and exit with a minimum idle time and delivers a synchronized, optionally filtered electrical-idle indication to the core. It sits in the core power domain beside the pad instance. Trim and bias buses go straight to the pad and are outside this block.

## Interface
- `SETTLE_CYC`, 64: cycles held in each settle state (≥2).
- `EI_MIN_CYC`, 16: minimum cycles `pad_tx_ei_o` stays high once asserted (≥1).
- `EI_FILT_CYC`, 8: stability window of the EI detect filter (≥1). Used only with the macro.
- `clk_i` in 1: clock. Single clock domain.
- `rst_i` in 1: reset, synchronous, active-high.
- `link_en_i` in 1: request link up (1) or down (0).
- `rx_mode_i` in 1: direction, 0 = TX, 1 = RX. Sampled only in OFF.
- `tx_ei_req_i` in 1: request transmitter electrical idle while ACTIVE in TX mode.
- `ready_o` out 1: link ACTIVE.
- `rx_idle_o` out 1: electrical idle seen on the pads.
- `pad_rterm_en_o`, `pad_rx_en_o`, `pad_rx_vcm_en_o`, `pad_ei_detect_en_o` out 1: receive-side pad enables.
- `pad_tx_en_o`, `pad_tx_vcm_en_o`, `pad_tx_ei_o` out 1: transmit-side pad enables.
- `pad_ei_detect_i` in 1: raw EI detect from the pad. Asynchronous.

## Operation
- States: OFF, TERM, ENABLE, ACTIVE, DRAIN. A single down-counter of width clog2(max(SETTLE_CYC, EI_MIN_CYC)) runs all settle and drain timing.
- All outputs are registered.
- Reset values:
  - all `pad_*_o` = 0
  - `ready_o` = 0
  - `rx_idle_o` = 1
  - state = OFF
  - mode register = 0
- **OFF.** All outputs 0 except `rx_idle_o` = 1. If `link_en_i` = 1: latch `rx_mode_i` into the mode register, load the counter with SETTLE_CYC−1, go to TERM.
- **TERM.**
  - TX mode: `pad_tx_vcm_en_o` = 1.
  - RX mode: `pad_rterm_en_o` = 1 and `pad_rx_vcm_en_o` = 1.
  - At count 0: reload SETTLE_CYC−1, go to ENABLE.
- **ENABLE.** The TERM outputs stay asserted, plus:
  - TX mode: `pad_tx_en_o` = 1 and `pad_tx_ei_o` = 1, so the driver starts in idle.
  - RX mode: `pad_rx_en_o` = 1 and `pad_ei_detect_en_o` = 1.
  - At count 0: go to ACTIVE.
- **ACTIVE.** `ready_o` = 1. In TX mode, `pad_tx_ei_o` follows `tx_ei_req_i` with a 1-cycle register delay, subject to the EI minimum:
  - On any 0→1 transition of `pad_tx_ei_o`, load the EI counter with EI_MIN_CYC−1.
  - `pad_tx_ei_o` cannot fall before that counter reaches 0.
  - The forced idle carried over from ENABLE counts as an assertion.
- **DRAIN entry.** `link_en_i` = 0 in TERM, ENABLE or ACTIVE sends the block to DRAIN next cycle and loads EI_MIN_CYC−1.
- **DRAIN.**
  - `ready_o` = 0.
  - TX mode: `pad_tx_ei_o` = 1, `pad_tx_en_o` and `pad_tx_vcm_en_o` keep their ENABLE/TERM values.
  - RX mode: `pad_rx_en_o` = 0 and `pad_ei_detect_en_o` = 0; termination and VCM stay on.
  - At count 0: go to OFF.
- A request arriving mid-sequence is never aborted abruptly. `link_en_i` = 1 during DRAIN is ignored; the block finishes DRAIN, passes through OFF for one cycle, then restarts.
- Changes to `rx_mode_i` outside OFF are ignored.
- `tx_ei_req_i` is ignored in RX mode and in every state except ACTIVE.
- **RX idle path.** `pad_ei_detect_i` passes through a 2-flop synchronizer (reset 1). `rx_idle_o` = filtered synchronized value when state = ACTIVE and mode = RX; otherwise it is forced to 1.

## Timing
- `link_en_i` rises with the block in OFF at edge 0:
  - TERM outputs visible after edge 1.
  - ENABLE outputs after edge 1+SETTLE_CYC.
  - `ready_o` after edge 1+2·SETTLE_CYC.
- `link_en_i` falls in ACTIVE at edge n:
  - `ready_o` = 0 after edge n+1.
  - All pad outputs = 0 after edge n+1+EI_MIN_CYC.
- `tx_ei_req_i` to `pad_tx_ei_o`: 1 cycle for entry; exit no earlier than EI_MIN_CYC cycles after entry.
- Pad EI to `rx_idle_o`:
  - With filter: 2 + EI_FILT_CYC cycles.
  - Without filter: 3 cycles.
- `rst_i` mid-sequence: every output reaches its reset value on the next edge. No drain is performed.

## Configuration
- Macro: `HPLVDS_EI_FILTER_EN`.
- **Defined.** The synchronized EI value must hold the same level for EI_FILT_CYC consecutive cycles before the filtered value changes. The filter register resets to 1, and the stability counter restarts on any toggle.
- **Undefined.**
  - The filter is removed and `EI_FILT_CYC` is unused.
  - The filtered value is one extra register stage after the synchronizer, giving 3-cycle latency.

## Test plan
- **TX bring-up.** SETTLE_CYC=4, TX mode, `link_en_i`↑ at cycle 0:
  - `pad_tx_vcm_en_o`=1 at cycle 1.
  - `pad_tx_en_o`=`pad_tx_ei_o`=1 at cycle 5.
  - `ready_o`=1 at cycle 9.
  - `pad_tx_ei_o` stays 1 until the EI minimum expires.
- **EI minimum.** EI_MIN_CYC=3, ACTIVE TX, `tx_ei_req_i` pulsed for 1 cycle → `pad_tx_ei_o` high for exactly 3 cycles. A second pulse 5 cycles later repeats the 3-cycle window.
- **RX idle filter.** RX ACTIVE, macro on, EI_FILT_CYC=8:
  - `pad_ei_detect_i` glitching for 5 cycles → `rx_idle_o` unchanged.
  - A steady 1 → `rx_idle_o`=1 exactly 10 cycles after the edge.
- **Teardown.** Link down in RX ACTIVE:
  - `pad_rx_en_o`=0 and `ready_o`=0 after 1 cycle.
  - `pad_rterm_en_o`=0 after 1+EI_MIN_CYC cycles.
  - `link_en_i` re-raised during DRAIN → full sequence restarts after one OFF cycle.
- **Mode and reset.**
  - Toggling `rx_mode_i` during TERM has no effect.
  - `rst_i` for 1 cycle in ENABLE → all pad outputs 0, `rx_idle_o`=1 on the next edge.
